// File: rtl/adc_pkg.sv
// Shared constants for the ADC0809 conversion sequencer: FSM encoding and
// default timing parameters.
package adc_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_PULSE   = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_READ    = 3'd5;

    localparam int unsigned CLK_DIV_DEF     = 4;
    localparam int unsigned PULSE_CYC_DEF   = 2;
    localparam int unsigned READ_CYC_DEF    = 2;
    localparam int unsigned TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Synchronous active-high reset clears both stages.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc0809_seq.sv
// ADC0809 conversion sequencer: channel select, ALE/START pulse, EOC wait,
// OE read and capture. Define ADC_TIMEOUT_EN to build the EOC-wait timeout.
module adc0809_seq
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
    parameter int unsigned PULSE_CYC   = PULSE_CYC_DEF,
    parameter int unsigned READ_CYC    = READ_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START_REQ,
    input  logic [2:0] CH,
    input  logic       ACK,
    input  logic       EOC,
    input  logic [7:0] ADC_D,
    output logic       ADC_CLK,
    output logic [2:0] ADDR,
    output logic       ALE,
    output logic       START,
    output logic       OE,
    output logic [7:0] DATA,
    output logic       DONE,
    output logic       BUSY,
    output logic       ERR
);

    localparam int unsigned DW   = $clog2(CLK_DIV + 1);
    localparam int unsigned CMAX = (PULSE_CYC > READ_CYC) ? PULSE_CYC : READ_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    logic [DW-1:0] div_q;
    logic          adc_clk_q;
    logic          eoc_s;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          pulse_q, oe_q, busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q     <= '0;
            adc_clk_q <= 1'b0;
        end else if (div_q == DW'(CLK_DIV - 1)) begin
            div_q     <= '0;
            adc_clk_q <= ~adc_clk_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    sync_2ff u_eoc_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (EOC),
        .q_o   (eoc_s)
    );

`ifdef ADC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
`ifdef ADC_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        if (ACK) done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START_REQ) begin
                    addr_d  = CH;
                    done_d  = 1'b0;
`ifdef ADC_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cyc_d   = '0;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cyc_q == CW'(PULSE_CYC - 1)) begin
                    state_d = S_WAIT_LO;
`ifdef ADC_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_WAIT_LO: if (!eoc_s) state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (eoc_s) begin
                    cyc_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // capture wins over a coincident ACK
                if (cyc_q == CW'(READ_CYC - 1)) begin
                    data_d  = ADC_D;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef ADC_TIMEOUT_EN
        if (state_q == S_WAIT_LO || state_q == S_WAIT_HI) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            pulse_q <= (state_d == S_PULSE);
            oe_q    <= (state_d == S_READ);
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef ADC_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign ADC_CLK = adc_clk_q;
    assign ADDR    = addr_q;
    assign ALE     = pulse_q;
    assign START   = pulse_q;
    assign OE      = oe_q;
    assign DATA    = data_q;
    assign DONE    = done_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_adc0809_seq.sv
// Directed plus randomized bench for adc0809_seq with a behavioural ADC model
// and an event-level reference model of DATA/DONE/ERR.
module tb_adc0809_seq;

    localparam int DIV   = 4;
    localparam int PULSE = 2;
    localparam int READ  = 2;
    localparam int TMO   = 64;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START_REQ = 1'b0;
    logic [2:0] CH = 3'd0;
    logic       ACK = 1'b0;
    logic       EOC = 1'b1;
    logic [7:0] ADC_D;
    logic       ADC_CLK;
    logic [2:0] ADDR;
    logic       ALE, START, OE;
    logic [7:0] DATA;
    logic       DONE, BUSY, ERR;

    logic [7:0] adc_val = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_done = 1'b0;
    logic       m_err  = 1'b0;

    always #5 CLK = ~CLK;

    // ADC drives the result only while OE is high, garbage otherwise
    assign ADC_D = OE ? adc_val : ~adc_val;

    adc0809_seq #(
        .CLK_DIV     (DIV),
        .PULSE_CYC   (PULSE),
        .READ_CYC    (READ),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START_REQ (START_REQ),
        .CH        (CH),
        .ACK       (ACK),
        .EOC       (EOC),
        .ADC_D     (ADC_D),
        .ADC_CLK   (ADC_CLK),
        .ADDR      (ADDR),
        .ALE       (ALE),
        .START     (START),
        .OE        (OE),
        .DATA      (DATA),
        .DONE      (DONE),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, ADDR, 0);
        chk({tag, "_data"}, DATA, 0);
        chk({tag, "_ctl"}, {ADC_CLK, ALE, START, OE, DONE, BUSY, ERR}, 0);
    endtask

    task automatic ack_pulse();
        @(posedge CLK); #1 ACK = 1'b1;
        @(posedge CLK); #1 ACK = 1'b0;
        m_done = 1'b0;
        chk("ack_done", DONE, m_done);
        chk("ack_data", DATA, m_data);
    endtask

    task automatic conv(input logic [2:0] ch, input logic [7:0] val,
                        input int lo, input int hi, input bit inject,
                        input bit ack_col, input bit rst_oe);
        int cyc = 0, ale_n = 0, ale_w = 0, ale_first = -1;
        int oe_w = 0, fall = -1, eoc_t = -1;
        bit prev_ale = 0, fin = 0, addr_bad = 0, start_bad = 0;
        adc_val = val;
        EOC = 1'b1;
        @(posedge CLK); #1 START_REQ = 1'b1; CH = ch;
        @(posedge CLK); #1 START_REQ = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        chk("req_busy", BUSY, 1);
        chk("req_addr", ADDR, ch);
        chk("req_flags", {DONE, ERR, ALE}, {m_done, m_err, 1'b0});
        while (!fin && cyc < 3000) begin
            @(posedge CLK);
            cyc++;
            #1;
            START_REQ = 1'b0;
            ACK = 1'b0;
            if (ALE && !prev_ale) begin
                ale_n++;
                if (ale_first < 0) ale_first = cyc;
            end
            if (ALE) ale_w++;
            if (START !== ALE) start_bad = 1;
            if (!ALE && prev_ale && fall < 0) fall = cyc;
            prev_ale = ALE;
            if (ADDR !== ch) addr_bad = 1;
            if (fall >= 0 && cyc == fall + lo) EOC = 1'b0;
            if (fall >= 0 && cyc == fall + lo + hi) begin
                EOC = 1'b1;
                eoc_t = cyc;
            end
            if (inject && fall >= 0 && cyc == fall + lo + 5) begin
                START_REQ = 1'b1;
                CH = 3'd2;
            end
            if (OE) oe_w++;
            if (rst_oe && OE) begin
                RST = 1'b1;
                @(posedge CLK); #1 RST = 1'b0;
                EOC = 1'b1;
                m_data = 8'h00;
                m_done = 1'b0;
                chk_all_zero("rst_mid");
                return;
            end
            if (ack_col && OE && oe_w == READ) ACK = 1'b1;
            if (DONE) fin = 1;
        end
        ACK = 1'b0;
        chk("done_seen", fin, 1);
        m_data = val;
        m_done = 1'b1;
        chk("data", DATA, m_data);
        chk("done", DONE, m_done);
        chk("busy_oe_end", {BUSY, OE}, 0);
        chk("ale_count", ale_n, 1);
        chk("ale_width", ale_w, PULSE);
        chk("ale_start", ale_first, 1);
        chk("addr_stable", addr_bad, 0);
        chk("start_eq_ale", start_bad, 0);
        chk("oe_width", oe_w, READ);
        chk("eoc_to_done", cyc - eoc_t, 3 + READ);
        chk("err", ERR, m_err);
    endtask

    initial begin
        int t, d;
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RST = 1'b0;

        t = 0;
        begin
            logic prev;
            prev = ADC_CLK;
            while (ADC_CLK === prev && t < 20) begin
                @(posedge CLK); #1; t++;
            end
            for (int k = 0; k < 2; k++) begin
                prev = ADC_CLK;
                d = 0;
                while (ADC_CLK === prev && d < 20) begin
                    @(posedge CLK); #1; d++;
                end
                chk("adc_clk_half", d, DIV);
            end
        end

        conv(3'd5, 8'hA7, 10, 40, 0, 0, 0);
        ack_pulse();
        conv(3'd0, 8'h00, 10, 40, 0, 0, 0);
        conv(3'd6, 8'($urandom), 5, 20, 1, 0, 0);
        conv(3'd3, 8'($urandom), 4, 12, 0, 1, 0);
        conv(3'd1, 8'h5C, 6, 15, 0, 0, 1);
        conv(3'd4, 8'h3E, 6, 15, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            conv(3'($urandom), 8'($urandom), int'($urandom_range(2, 15)),
                 int'($urandom_range(8, 30)), 0, 0, 0);
            if ($urandom_range(0, 1) == 1) ack_pulse();
        end

`ifdef ADC_TIMEOUT_EN
        EOC = 1'b1;
        @(posedge CLK); #1 START_REQ = 1'b1; CH = 3'd7;
        @(posedge CLK); #1 START_REQ = 1'b0;
        m_done = 1'b0;
        t = 0;
        while (BUSY && t < 500) begin
            @(posedge CLK); #1; t++;
        end
        m_err = 1'b1;
        chk("tmo_window", (t >= 1 + PULSE + TMO - 2) && (t <= 1 + PULSE + TMO + 2), 1);
        chk("tmo_err", ERR, m_err);
        chk("tmo_done", DONE, m_done);
        chk("tmo_data", DATA, m_data);
        conv(3'd2, 8'h91, 5, 10, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
